// File: rtl/gpio_cond_pkg.sv
// gpio_cond_pkg
//   Shared definitions for the GPIO input conditioner: the per-pin debounce
//   state encoding, the counter width helper and the smallest debounce
//   length the pin FSM can qualify with.
package gpio_cond_pkg;

  // Below two cycles there is no window in which a glitch could return to
  // the accepted level and be rejected.
  localparam int MIN_DEBOUNCE_CYCLES = 2;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } debounce_state_e;

  // The counter only has to reach DEBOUNCE_CYCLES-1, so clog2(cycles) bits
  // are enough; never drop below one bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage : gpio_cond_pkg

// File: rtl/gpio_debounce_pin.sv
// gpio_debounce_pin
//   Conditions one raw pad bit: a two-flop synchronizer followed by a
//   debounce FSM. A new level is accepted only after the synchronized input
//   has differed from the accepted level for DEBOUNCE_CYCLES consecutive
//   cycles; any return to the accepted level restarts qualification.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   STABLE   | sync2 matches the accepted level, counter idle at zero
//   COUNTING | sync2 differs from the accepted level, counter = run length
//
// Ports
//   clock        block clock
//   reset        synchronous, active-high reset
//   pad_in       raw asynchronous pad level
//   stable       debounced level
//   rise_strobe  high in the cycle whose closing edge accepts a new 1
//   fall_strobe  high in the cycle whose closing edge accepts a new 0
module gpio_debounce_pin
  import gpio_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic pad_in,
  output logic stable,
  output logic rise_strobe,
  output logic fall_strobe
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  debounce_state_e state_q;
  debounce_state_e state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic            stable_q;
  logic            stable_d;
  logic            commit;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      state_q  <= STABLE;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync1_q  <= pad_in;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    stable_d = stable_q;
    commit   = 1'b0;
    case (state_q)
      STABLE: begin
        if (sync2_q != stable_q) begin
          state_d = COUNTING;
          cnt_d   = CNT_ONE;
        end
      end
      COUNTING: begin
        if (sync2_q == stable_q) begin
          // glitch: back to the accepted level, start over from zero
          state_d = STABLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = STABLE;
          stable_d = sync2_q;
          commit   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE;
      end
    endcase
  end

  // The strobes decode registered state only (no path from pad_in). They are
  // high during the cycle whose closing edge flips stable_q, so the top's
  // pending registers capture the event on the same edge as the new level.
  assign stable      = stable_q;
  assign rise_strobe = commit & sync2_q;
  assign fall_strobe = commit & ~sync2_q;

endmodule : gpio_debounce_pin

// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner
//   Sits between the pad tristate logic and the SoC gpio_input bus. Every pin
//   is synchronized and debounced; accepted rising/falling edges set sticky
//   pending bits that software clears with a masked strobe, and a registered
//   maskable interrupt summarizes the pending state.
//
// Ports
//   clock         block clock (single domain)
//   reset         synchronous, active-high reset
//   gpio_pad_in   raw asynchronous pad levels
//   rise_enable   per-pin enable for capturing rising edges
//   fall_enable   per-pin enable for capturing falling edges
//   irq_enable    per-pin interrupt mask
//   clear_valid   one-cycle strobe qualifying clear_mask
//   clear_mask    pins whose rise and fall pending bits are cleared
//   gpio_stable   debounced levels, drives SoC gpio_input
//   rise_pending  sticky rising-edge flags
//   fall_pending  sticky falling-edge flags
//   irq           registered interrupt request
module gpio_input_conditioner
  import gpio_cond_pkg::*;
#(
  parameter int GPIO_WIDTH      = 3,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [GPIO_WIDTH-1:0] gpio_pad_in,
  input  logic [GPIO_WIDTH-1:0] rise_enable,
  input  logic [GPIO_WIDTH-1:0] fall_enable,
  input  logic [GPIO_WIDTH-1:0] irq_enable,
  input  logic                  clear_valid,
  input  logic [GPIO_WIDTH-1:0] clear_mask,
  output logic [GPIO_WIDTH-1:0] gpio_stable,
  output logic [GPIO_WIDTH-1:0] rise_pending,
  output logic [GPIO_WIDTH-1:0] fall_pending,
  output logic                  irq
);

  // An undersized debounce length would leave no glitch window; clamp it.
  localparam int DEB_EFF = (DEBOUNCE_CYCLES < MIN_DEBOUNCE_CYCLES) ?
                           MIN_DEBOUNCE_CYCLES : DEBOUNCE_CYCLES;

  logic [GPIO_WIDTH-1:0] rise_strobe;
  logic [GPIO_WIDTH-1:0] fall_strobe;
  logic [GPIO_WIDTH-1:0] clear_bits;

  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pin
    gpio_debounce_pin #(
      .DEBOUNCE_CYCLES(DEB_EFF)
    ) u_pin (
      .clock       (clock),
      .reset       (reset),
      .pad_in      (gpio_pad_in[i]),
      .stable      (gpio_stable[i]),
      .rise_strobe (rise_strobe[i]),
      .fall_strobe (fall_strobe[i])
    );
  end

  assign clear_bits = clear_valid ? clear_mask : '0;

  // Clear is applied first and the new event ORed in afterwards, so an edge
  // landing in the same cycle as a clear is never lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      rise_pending <= '0;
      fall_pending <= '0;
      irq          <= 1'b0;
    end else begin
      rise_pending <= (rise_pending & ~clear_bits) | (rise_strobe & rise_enable);
      fall_pending <= (fall_pending & ~clear_bits) | (fall_strobe & fall_enable);
      irq          <= |((rise_pending | fall_pending) & irq_enable);
    end
  end

endmodule : gpio_input_conditioner
